tdm_demux1x4: RTL and testbench
===============================

TDM_DEMUX1X4 -- requirements
Module: tdm_demux1x4

Interface
REQ-001 SHALL have parameter FRAME_TIMEOUT, default 15, the number of idle cycles in RUN before returning to IDLE (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset: one clock, synchronous, active-high.
REQ-004 SHALL have port din  input  1  serial time-division-multiplexed data bit.
REQ-005 SHALL have port din_valid  input  1  qualifies din and sync for the current cycle.
REQ-006 SHALL have port sync  input  1  marks the current valid beat as channel slot 0.
REQ-007 SHALL have port sel  output  2  channel slot expected on the next valid beat (registered).
REQ-008 SHALL have port f  output  [0:3]  last complete frame; f[n] is channel n (registered).
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when f is updated.
REQ-010 SHALL have port err  output  1  sticky framing-error flag.

Function
REQ-011 SHALL implement a 2-state FSM: IDLE (unsynchronised) and RUN (synchronised).
REQ-012 IDLE: a beat with din_valid=1 and sync=0 SHALL be discarded, with sel held at 0.
REQ-013 IDLE: a beat with din_valid=1 and sync=1 SHALL store din into staging slot 0, set sel=1 and enter RUN.
REQ-014 RUN: each beat with din_valid=1 and sync=0 at sel=1..3 SHALL store din into staging[sel] and increment sel.
REQ-015 On the beat at sel=3, on that same edge the block SHALL load f with {staging0, staging1, staging2, din} and wrap sel to 0; frame_valid SHALL be 1 for exactly the following cycle.
REQ-016 RUN at sel=0: a beat with sync=1 SHALL start the next frame (store slot 0, sel=1).
REQ-017 RUN at sel=0: a beat with sync=0 SHALL set err, discard the beat, and return to IDLE.
REQ-018 RUN at sel!=0: a beat with sync=1 SHALL set err, discard the partial frame, store din as slot 0, and set sel=1 (resynchronise); no frame_valid.
REQ-019 sync with din_valid=0 SHALL be ignored in every state.
REQ-020 RUN: an idle counter SHALL increment on each cycle with din_valid=0, and SHALL clear on each cycle with din_valid=1.
REQ-021 When the idle counter reaches FRAME_TIMEOUT, the block SHALL enter IDLE, set sel=0 and discard the partial frame; err is unaffected.
REQ-022 f SHALL hold its value between frames; it is never cleared except by rst.
REQ-023 err SHALL remain 1 until rst.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set: state=IDLE, sel=0, f=4'b0000, frame_valid=0, err=0, staging=0, idle counter=0.
REQ-025 rst SHALL override din_valid/sync in the same cycle, and a partial frame SHALL be lost on reset mid-frame.
REQ-026 The first beat after rst deasserts SHALL be evaluated under IDLE rules.

Configuration
REQ-027 Macro TDM_DEMUX_PARITY_EN, when defined, SHALL add a fifth slot: after slot 3, one extra valid beat carrying even parity over f[0:3].
REQ-028 With TDM_DEMUX_PARITY_EN, the block SHALL add ports par_phase (output 1, high while the parity beat is expected) and par_err (output 1, one-cycle pulse).
REQ-029 With TDM_DEMUX_PARITY_EN, the frame SHALL commit on the parity beat. If parity matches, f is updated and frame_valid pulses; if it mismatches, f holds, par_err pulses and err is unaffected. sel SHALL read 0 during par_phase, and sync on the parity beat SHALL follow REQ-018.
REQ-030 Without TDM_DEMUX_PARITY_EN, neither par_phase nor par_err SHALL exist, and the frame SHALL be 4 slots as described in REQ-014/REQ-015.

Verification
REQ-031 Reset, then beats din=0,1,0,1 with sync on the first beat -> f=0101, a single frame_valid pulse, err=0, sel sequence 1,2,3,0.
REQ-032 Two back-to-back frames 0101 then 1100 with no gaps -> f=0101, then f=1100, with two frame_valid pulses 4 cycles apart.
REQ-033 sync asserted on the 3rd beat of a frame -> err=1, no frame_valid, and that beat taken as slot 0; the following 3 beats 1,1,1 -> f={din of the 3rd beat},1,1,1.
REQ-034 After 2 beats, din_valid=0 for FRAME_TIMEOUT (15) cycles -> state IDLE, sel=0, f unchanged; a new sync frame 1010 -> f=1010.
REQ-035 rst=1 asserted for one cycle mid-frame (after 2 beats) -> all outputs at their reset values; a subsequent beat without sync is discarded.
REQ-036 With TDM_DEMUX_PARITY_EN: frame 0111 followed by parity beat 1 -> f=0111 and frame_valid; frame 0111 followed by parity beat 0 -> par_err pulse and f unchanged.

Source files
------------

// File: rtl/tdm_demux1x4.sv
// rtl/tdm_demux1x4.sv - 1-to-4 serial TDM demultiplexer with sync tracking and frame timeout
// Optional parity slot after channel 3 enabled by `define TDM_DEMUX_PARITY_EN
module tdm_demux1x4 #(
  parameter int FRAME_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sync,
  output logic [1:0] sel,
  output logic [0:3] f,
  output logic       frame_valid,
  output logic       err
`ifdef TDM_DEMUX_PARITY_EN
  ,
  output logic       par_phase,
  output logic       par_err
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] TIMEOUT = 8'(FRAME_TIMEOUT);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [0:2] stg_q, stg_d;
  logic [0:3] f_q, f_d;
  logic       fv_q, fv_d;
  logic       err_q, err_d;
  logic [7:0] idle_q, idle_d;
`ifdef TDM_DEMUX_PARITY_EN
  logic       par_q, par_d;
  logic       stg3_q, stg3_d;
  logic       perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      stg_q   <= 3'b000;
      f_q     <= 4'b0000;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 8'd0;
`ifdef TDM_DEMUX_PARITY_EN
      par_q   <= 1'b0;
      stg3_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      stg_q   <= stg_d;
      f_q     <= f_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
`ifdef TDM_DEMUX_PARITY_EN
      par_q   <= par_d;
      stg3_q  <= stg3_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    stg_d   = stg_q;
    f_d     = f_q;
    fv_d    = 1'b0;
    err_d   = err_q;
    idle_d  = idle_q;
`ifdef TDM_DEMUX_PARITY_EN
    par_d   = par_q;
    stg3_d  = stg3_q;
    perr_d  = 1'b0;
`endif
    if (state_q == IDLE) begin
      idle_d = 8'd0;
      if (din_valid && sync) begin
        stg_d[0] = din;
        sel_d    = 2'd1;
        state_d  = RUN;
      end
    end else if (!din_valid) begin
      idle_d = idle_q + 8'd1;
      if (idle_q + 8'd1 == TIMEOUT) begin
        state_d = IDLE;
        sel_d   = 2'd0;
        idle_d  = 8'd0;
`ifdef TDM_DEMUX_PARITY_EN
        par_d   = 1'b0;
`endif
      end
    end else begin
      idle_d = 8'd0;
      if (sync) begin
        // sync anywhere but a frame boundary is a resync: flag it and restart at slot 0
`ifdef TDM_DEMUX_PARITY_EN
        if (sel_q != 2'd0 || par_q) err_d = 1'b1;
        par_d = 1'b0;
`else
        if (sel_q != 2'd0) err_d = 1'b1;
`endif
        stg_d[0] = din;
        sel_d    = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
      end else if (par_q) begin
        if (din == ^{stg_q, stg3_q}) begin
          f_d  = {stg_q, stg3_q};
          fv_d = 1'b1;
        end else begin
          perr_d = 1'b1;
        end
        par_d = 1'b0;
        sel_d = 2'd0;
`endif
      end else if (sel_q == 2'd0) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        case (sel_q)
          2'd1: begin
            stg_d[1] = din;
            sel_d    = 2'd2;
          end
          2'd2: begin
            stg_d[2] = din;
            sel_d    = 2'd3;
          end
          default: begin
`ifdef TDM_DEMUX_PARITY_EN
            stg3_d = din;
            par_d  = 1'b1;
`else
            f_d    = {stg_q, din};
            fv_d   = 1'b1;
`endif
            sel_d  = 2'd0;
          end
        endcase
      end
    end
  end

  assign sel         = sel_q;
  assign f           = f_q;
  assign frame_valid = fv_q;
  assign err         = err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_phase   = par_q;
  assign par_err     = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux1x4.sv
// tb/tb_tdm_demux1x4.sv - scoreboard bench for tdm_demux1x4 (handles TDM_DEMUX_PARITY_EN builds too)
module tb_tdm_demux1x4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       sync;
  logic [1:0] sel;
  logic [0:3] f;
  logic       frame_valid;
  logic       err;
`ifdef TDM_DEMUX_PARITY_EN
  logic       par_phase;
  logic       par_err;
  int         perr_count = 0;
`endif

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [3:0] sb[$];
  int         fv_times[$];

  tdm_demux1x4 #(.FRAME_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .sel(sel), .f(f), .frame_valid(frame_valid), .err(err)
`ifdef TDM_DEMUX_PARITY_EN
    , .par_phase(par_phase), .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: every frame_valid pulse must match the oldest pending frame
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_times.push_back(cyc);
      if (sb.size() == 0) check_eq("fv_spurious", 32'(frame_valid), 32'd0);
      else check_eq("frame_f", 32'(f), 32'(sb.pop_front()));
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (par_err) perr_count <= perr_count + 1;
`endif
  end

  task automatic beat(input logic d, input logic s);
    din = d; din_valid = 1'b1; sync = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din = 1'($urandom); din_valid = 1'b0; sync = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic par_beat(input logic [3:0] b);
`ifdef TDM_DEMUX_PARITY_EN
    beat(^b, 1'b0);
`else
    if (b === 4'bxxxx) $display("unreachable");
`endif
  endtask

  task automatic send_frame(input logic [3:0] b);
    sb.push_back(b);
    beat(b[3], 1'b1); beat(b[2], 1'b0); beat(b[1], 1'b0); beat(b[0], 1'b0);
    par_beat(b);
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    logic [3:0] rb;
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_f", 32'(f), 32'd0);
    check_eq("rst_fv", 32'(frame_valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // single frame 0101 with sel sequence
    n0 = fv_times.size();
    sb.push_back(4'b0101);
    beat(1'b0, 1'b1); check_eq("sel_1", 32'(sel), 32'd1);
    beat(1'b1, 1'b0); check_eq("sel_2", 32'(sel), 32'd2);
    beat(1'b0, 1'b0); check_eq("sel_3", 32'(sel), 32'd3);
    beat(1'b1, 1'b0); check_eq("sel_0", 32'(sel), 32'd0);
    par_beat(4'b0101);
    idle(2);
    check_eq("one_fv", 32'(fv_times.size() - n0), 32'd1);
    check_eq("f_0101", 32'(f), 32'h5);
    check_eq("err_clean", 32'(err), 32'd0);

    // back-to-back frames
    n0 = fv_times.size();
    send_frame(4'b0101);
    send_frame(4'b1100);
    idle(1);
    check_eq("b2b_count", 32'(fv_times.size() - n0), 32'd2);
    if (fv_times.size() - n0 == 2)
      check_eq("b2b_gap", 32'(fv_times[n0+1] - fv_times[n0]), 32'(FLEN));
    check_eq("f_1100", 32'(f), 32'hC);

    // timeout after 2 beats: still RUN at 14 idle cycles, IDLE at 15
    beat(1'b1, 1'b1); beat(1'b0, 1'b0);
    idle(14);
    check_eq("to_14_sel", 32'(sel), 32'd2);
    idle(1);
    check_eq("to_15_sel", 32'(sel), 32'd0);
    check_eq("to_f_held", 32'(f), 32'hC);
    beat(1'b1, 1'b0);
    check_eq("to_discard_sel", 32'(sel), 32'd0);
    check_eq("to_err", 32'(err), 32'd0);
    send_frame(4'b1010);
    idle(1);
    check_eq("f_1010", 32'(f), 32'hA);

    // sync on 3rd beat: resync, that beat becomes slot 0
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b0, 1'b1);
    check_eq("resync_err", 32'(err), 32'd1);
    check_eq("resync_sel", 32'(sel), 32'd1);
    sb.push_back(4'b0111);
    beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
    par_beat(4'b0111);
    idle(1);
    check_eq("f_0111", 32'(f), 32'h7);

    // unsynced beat at a frame boundary
    do_reset();
    check_eq("err_cleared", 32'(err), 32'd0);
    send_frame(4'b0011);
    beat(1'b1, 1'b0);
    check_eq("bnd_err", 32'(err), 32'd1);
    check_eq("bnd_sel", 32'(sel), 32'd0);
    beat(1'b1, 1'b0);
    check_eq("idle_discard", 32'(sel), 32'd0);

    // mid-frame reset with din_valid/sync asserted
    beat(1'b1, 1'b1); beat(1'b1, 1'b0);
    rst = 1'b1; din = 1'b1; din_valid = 1'b1; sync = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0; sync = 1'b0;
    check_eq("mrst_sel", 32'(sel), 32'd0);
    check_eq("mrst_f", 32'(f), 32'd0);
    check_eq("mrst_fv", 32'(frame_valid), 32'd0);
    check_eq("mrst_err", 32'(err), 32'd0);
    beat(1'b1, 1'b0);
    check_eq("mrst_nosync", 32'(sel), 32'd0);

    // sync without din_valid is ignored
    din_valid = 1'b0; sync = 1'b1; @(negedge clk);
    check_eq("ign_idle", 32'(sel), 32'd0);
    beat(1'b0, 1'b1); beat(1'b1, 1'b0);
    din_valid = 1'b0; sync = 1'b1; @(negedge clk);
    check_eq("ign_run_sel", 32'(sel), 32'd2);
    check_eq("ign_run_err", 32'(err), 32'd0);
    sb.push_back(4'b0110);
    beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    par_beat(4'b0110);
    idle(1);

    // random frames with short gaps
    for (int i = 0; i < 8; i++) begin
      rb = 4'($urandom);
      send_frame(rb);
      idle($urandom_range(0, 5));
    end
    idle(1);
    check_eq("rand_err", 32'(err), 32'd0);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(4'b0111);
    idle(1);
    check_eq("par_ok_f", 32'(f), 32'h7);
    n0 = perr_count;
    beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
    check_eq("par_phase", 32'(par_phase), 32'd1);
    beat(1'b1, 1'b0);
    idle(1);
    check_eq("par_err_pulse", 32'(perr_count - n0), 32'd1);
    check_eq("par_f_held", 32'(f), 32'h7);
    check_eq("par_err_sticky", 32'(err), 32'd0);
`endif

    idle(2);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
